// File: rtl/nunchuck_led_cursor.sv
// -----------------------------------------------------------------------------
// nunchuck_led_cursor
//
// Purpose:
//   Turns the Nunchuck joystick X axis into a cursor on a 10-LED bar.
//   The cursor position (0..9) blinks. It moves in steps, one per motion tick,
//   and the stick sets both the direction and the speed of motion:
//     - inside the dead-zone, the cursor does not move;
//     - a moderate deflection steps every other tick;
//     - a large deflection steps every tick.
//   The Z button toggles a persistent mark under the cursor.
//   The C button clears all marks.
//
// Ports:
//   clk      in   1   system clock
//   rst      in   1   asynchronous reset, active low
//   stick_x  in   8   joystick X from the Nunchuck driver, 128 = centre
//   z        in   1   Z button, 1 = pressed, asynchronous to clk
//   c        in   1   C button, 1 = pressed, asynchronous to clk
//   leds     out  10  registered LED drive (marks XOR blinking cursor)
// -----------------------------------------------------------------------------
module nunchuck_led_cursor #(
    parameter int TICK_DIV    = 5_000_000,
    parameter int DEADZONE    = 24,
    parameter int FAST_THRESH = 96,
    parameter int BLINK_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] stick_x,
    input  logic       z,
    input  logic       c,
    output logic [9:0] leds
);

    localparam int              CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam int              BLK_W     = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);
    localparam logic [8:0]      DZ_MAG    = 9'(DEADZONE);
    localparam logic [8:0]      FAST_MAG  = 9'(FAST_THRESH);
    localparam logic [3:0]      POS_MAX   = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SLOW,
        S_FAST
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    // -------------------------------------------------------------------------
    // Motion-tick prescaler
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic             tick;

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Stick decode.
    // The stick value is used only on a tick, so it is effectively sampled
    // there. dev is signed 9-bit.
    // For stick_x = 0, dev = -128. Its magnitude is 128, which still fits in
    // the 9-bit magnitude.
    // -------------------------------------------------------------------------
    logic [8:0] dev;
    logic [8:0] mag;
    dir_t       dir;
    logic       is_fast;

    assign dev     = {1'b0, stick_x} - 9'd128;
    assign mag     = dev[8] ? (9'd0 - dev) : dev;
    assign is_fast = (mag > FAST_MAG);

    always_comb begin
        dir = DIR_NONE;
        if (mag > DZ_MAG) begin
            dir = dev[8] ? DIR_LEFT : DIR_RIGHT;
        end
    end

    // Saturating single step of the cursor; never wraps past either end.
    function automatic logic [3:0] step_pos(input logic [3:0] p, input dir_t d);
        if (d == DIR_RIGHT && p < POS_MAX) begin
            return p + 4'd1;
        end else if (d == DIR_LEFT && p != 4'd0) begin
            return p - 4'd1;
        end else begin
            return p;
        end
    endfunction

    // -------------------------------------------------------------------------
    // Motion FSM.
    // phase paces slow stepping. When phase = 1, the next slow tick is a
    // skip. last_dir detects a LEFT<->RIGHT reversal; a reversal always steps
    // immediately, so the cursor responds at once.
    // -------------------------------------------------------------------------
    state_t     state;
    logic [3:0] pos;
    logic       phase;
    dir_t       last_dir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pos      <= 4'd0;
            phase    <= 1'b0;
            last_dir <= DIR_NONE;
        end else if (tick) begin
            case (state)
                S_IDLE: begin
                    if (dir != DIR_NONE) begin
                        pos      <= step_pos(pos, dir);
                        last_dir <= dir;
                        if (is_fast) begin
                            state <= S_FAST;
                            phase <= 1'b0;
                        end else begin
                            state <= S_SLOW;
                            phase <= 1'b1;
                        end
                    end
                end

                S_SLOW: begin
                    if (dir == DIR_NONE) begin
                        state <= S_IDLE;
                        phase <= 1'b0;
                    end else if (is_fast) begin
                        state    <= S_FAST;
                        pos      <= step_pos(pos, dir);
                        last_dir <= dir;
                        phase    <= 1'b0;
                    end else if (dir != last_dir) begin
                        pos      <= step_pos(pos, dir);
                        last_dir <= dir;
                        phase    <= 1'b1;
                    end else begin
                        if (!phase) begin
                            pos <= step_pos(pos, dir);
                        end
                        phase <= ~phase;
                    end
                end

                S_FAST: begin
                    if (dir == DIR_NONE) begin
                        state <= S_IDLE;
                        phase <= 1'b0;
                    end else if (is_fast) begin
                        pos      <= step_pos(pos, dir);
                        last_dir <= dir;
                    end else begin
                        // Downshift: normally no step on this tick. A
                        // reversal still steps now in the new direction.
                        state    <= S_SLOW;
                        phase    <= 1'b1;
                        last_dir <= dir;
                        if (dir != last_dir) begin
                            pos <= step_pos(pos, dir);
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    phase <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Button synchronisers and rising-edge detectors.
    // All history flops reset to 1. A button held through reset then looks
    // like it was already pressed, so it cannot fire an edge on release of
    // reset.
    // -------------------------------------------------------------------------
    logic z_meta, z_sync, z_prev;
    logic c_meta, c_sync, c_prev;
    logic z_edge, c_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_meta <= 1'b1;
            z_sync <= 1'b1;
            z_prev <= 1'b1;
            c_meta <= 1'b1;
            c_sync <= 1'b1;
            c_prev <= 1'b1;
        end else begin
            z_meta <= z;
            z_sync <= z_meta;
            z_prev <= z_sync;
            c_meta <= c;
            c_sync <= c_meta;
            c_prev <= c_sync;
        end
    end

    assign z_edge = z_sync & ~z_prev;
    assign c_edge = c_sync & ~c_prev;

    // -------------------------------------------------------------------------
    // Mark mask.
    // cursor_onehot is decoded from the current pos register. A Z edge in
    // the same cycle as a step therefore marks the LED the cursor is leaving.
    // Clear takes priority over toggle.
    // -------------------------------------------------------------------------
    logic [9:0] cursor_onehot;
    logic [9:0] mask;

    always_comb begin
        cursor_onehot = '0;
        for (int i = 0; i < 10; i++) begin
            cursor_onehot[i] = (pos == 4'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask <= '0;
        end else if (c_edge) begin
            mask <= '0;
        end else if (z_edge) begin
            mask <= mask ^ cursor_onehot;
        end
    end

    // -------------------------------------------------------------------------
    // Cursor blink: blink_on toggles on every BLINK_TICKS-th tick.
    // -------------------------------------------------------------------------
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_on;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered LED drive. The cursor LED shows its mark inverted while
    // blink_on is high.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds <= '0;
        end else begin
            leds <= mask ^ (blink_on ? cursor_onehot : 10'd0);
        end
    end

endmodule

// File: tb/tb_nunchuck_led_cursor.sv
// -----------------------------------------------------------------------------
// tb_nunchuck_led_cursor
//
// Purpose:
//   Directed self-checking bench for nunchuck_led_cursor.
//   The DUT runs with a short tick (TICK_DIV = 4) and a short blink
//   (BLINK_TICKS = 2).
//   The expected LED pattern for each check is built from:
//     - a hand-computed cursor position;
//     - a hand-computed mark mask;
//     - the blink phase, derived from the number of ticks since reset.
//   Checks are sampled mid-way between ticks, so the registered LED output
//   has already settled.
// -----------------------------------------------------------------------------
module tb_nunchuck_led_cursor;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] stick_x;
    logic       z;
    logic       c;
    logic [9:0] leds;

    int checks     = 0;
    int errors     = 0;
    int tick_count = 0;

    nunchuck_led_cursor #(
        .TICK_DIV   (4),
        .DEADZONE   (24),
        .FAST_THRESH(96),
        .BLINK_TICKS(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .stick_x(stick_x),
        .z      (z),
        .c      (c),
        .leds   (leds)
    );

    always #5 clk = ~clk;

    // Compare leds against an explicit value.
    task automatic check_value(input string tag, input logic [9:0] expected);
        checks++;
        assert (leds === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: leds=%h expected=%h", tag, leds, expected);
        end
    endtask

    // Expected leds = marks, with the cursor bit inverted while blinking on.
    // Blink turns on at tick 2, off at tick 4, and so on.
    task automatic check_output(input string tag, input int exp_pos,
                                input logic [9:0] exp_mask);
        logic [9:0] expected;
        expected = exp_mask;
        if (((tick_count / 2) % 2) == 1) begin
            expected[exp_pos] = ~expected[exp_pos];
        end
        check_value(tag, expected);
    endtask

    // Drive the stick, let exactly one tick happen, then check.
    task automatic apply_stimulus(input logic [7:0] sx, input int exp_pos,
                                  input logic [9:0] exp_mask, input string tag);
        stick_x = sx;
        repeat (4) @(posedge clk);
        #1;
        tick_count++;
        check_output(tag, exp_pos, exp_mask);
    endtask

    // Hold buttons for 48 cycles, then release for 8 cycles (14 ticks total).
    task automatic press_buttons(input logic zv, input logic cv);
        z = zv;
        c = cv;
        repeat (48) @(posedge clk);
        #1;
        z = 1'b0;
        c = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        tick_count += 14;
    endtask

    // Release reset on a falling edge. Then align so that each later group of
    // 4 cycles ends 2 cycles after a tick edge.
    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tick_count = 0;
    endtask

    initial begin
        rst     = 1'b0;
        stick_x = 8'd128;
        z       = 1'b0;
        c       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_leds", 10'h000);
        release_reset();

        // Centred stick: cursor stays at 0 and blinks every 2 ticks.
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(8'd128, 0, 10'h000, "idle_blink");
        end

        // Slow right (dev 52): step now, then every other tick.
        for (int k = 1; k <= 6; k++) begin
            apply_stimulus(8'd180, (k + 1) / 2, 10'h000, "slow_right");
        end

        // Fast right: one step per tick, saturating at 9.
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(8'd255, (4 + k > 9) ? 9 : 4 + k, 10'h000, "fast_right");
        end

        // dev 24 is inside the dead-zone.
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(8'd152, 9, 10'h000, "deadzone_pos");
        end

        // Full left from 9 down to 0, then hold at 0.
        for (int k = 1; k <= 11; k++) begin
            apply_stimulus(8'd0, (9 - k < 0) ? 0 : 9 - k, 10'h000, "fast_left");
        end
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(8'd152, 0, 10'h000, "deadzone_hold");
        end

        // dev 25 is just outside the dead-zone: slow motion.
        apply_stimulus(8'd153, 1, 10'h000, "dz_edge_1");
        apply_stimulus(8'd153, 1, 10'h000, "dz_edge_2");
        apply_stimulus(8'd153, 2, 10'h000, "dz_edge_3");

        // dev -24 is inside the dead-zone.
        apply_stimulus(8'd104, 2, 10'h000, "deadzone_neg_1");
        apply_stimulus(8'd104, 2, 10'h000, "deadzone_neg_2");

        // Move to pos 3, stop, and mark it with a long Z press.
        apply_stimulus(8'd153, 3, 10'h000, "to_pos3");
        apply_stimulus(8'd128, 3, 10'h000, "stop_pos3");
        press_buttons(1'b1, 1'b0);
        check_output("z_mark_pos3", 3, 10'h008);

        // Move to pos 5 and mark it too.
        apply_stimulus(8'd153, 4, 10'h008, "to_pos5_1");
        apply_stimulus(8'd153, 4, 10'h008, "to_pos5_2");
        apply_stimulus(8'd153, 5, 10'h008, "to_pos5_3");
        apply_stimulus(8'd128, 5, 10'h008, "stop_pos5");
        press_buttons(1'b1, 1'b0);
        check_output("z_mark_pos5", 5, 10'h028);

        // C clears all marks.
        press_buttons(1'b0, 1'b1);
        check_output("c_clear", 5, 10'h000);

        // Z and C together: clear wins, so bit 5 must not be set.
        press_buttons(1'b1, 1'b1);
        check_output("zc_together", 5, 10'h000);

        // Set a mark, go fast, then reset asynchronously mid-S_FAST while
        // Z is held.
        press_buttons(1'b1, 1'b0);
        check_output("z_mark_again", 5, 10'h020);
        apply_stimulus(8'd255, 6, 10'h020, "fast_before_rst_1");
        apply_stimulus(8'd255, 7, 10'h020, "fast_before_rst_2");
        z       = 1'b1;
        rst     = 1'b0;
        stick_x = 8'd128;
        #2;
        check_value("async_reset", 10'h000);
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_held", 10'h000);

        // Z held through the reset release must not toggle any mark.
        release_reset();
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(8'd128, 0, 10'h000, "z_held_rst");
        end
        z = 1'b0;
        apply_stimulus(8'd128, 0, 10'h000, "z_release_1");
        apply_stimulus(8'd128, 0, 10'h000, "z_release_2");

        // Fast right, then reverse to a moderate left (dev -68): step left
        // now, then every other tick.
        for (int k = 1; k <= 4; k++) begin
            apply_stimulus(8'd250, k, 10'h000, "fast_pre_rev");
        end
        apply_stimulus(8'd60, 3, 10'h000, "reverse_1");
        apply_stimulus(8'd60, 3, 10'h000, "reverse_2");
        apply_stimulus(8'd60, 2, 10'h000, "reverse_3");
        apply_stimulus(8'd60, 2, 10'h000, "reverse_4");
        apply_stimulus(8'd60, 1, 10'h000, "reverse_5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
